// File: rtl/function_eval_accumulator.sv
// -----------------------------------------------------------------------------
// function_eval_accumulator
//
// Command-driven front end for an external function pipeline. A GO command
// offers one operand pair to the pipeline; the pipeline later returns one
// term per channel. Those terms are added into per-channel signed saturating
// sums. CLEAR and READ first wait for the pipeline to drain. STATUS reports
// the sticky flags and the number of outstanding pairs.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   clk_en            global enable; low freezes every register
//   start, n          command strobe and opcode (0 CLEAR, 1 GO, 2 READ, 3 STATUS)
//   x_one, x_two      operands; x_one[2:0] is the READ channel select
//   result, done      response word (held) and one-cycle response pulse
//   busy              high while a command is in progress
//   issue_valid/ready operand-pair handshake towards the pipeline
//   issue_a, issue_b  captured operands
//   ret_valid         pipeline returns one term per channel this cycle
//   ret_data          channel c term at [c*DATA_WIDTH +: DATA_WIDTH], signed
// -----------------------------------------------------------------------------
module function_eval_accumulator #(
  parameter int DATA_WIDTH      = 32,
  parameter int N_WIDTH         = 2,
  parameter int NUM_CH          = 2,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic                         start,
  input  logic [N_WIDTH-1:0]           n,
  input  logic [DATA_WIDTH-1:0]        x_one,
  input  logic [DATA_WIDTH-1:0]        x_two,
  output logic [DATA_WIDTH-1:0]        result,
  output logic                         done,
  output logic                         busy,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [DATA_WIDTH-1:0]        issue_a,
  output logic [DATA_WIDTH-1:0]        issue_b,
  input  logic                         ret_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ret_data
);

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int STAT_W = OW + NUM_CH + 2;

  localparam logic [N_WIDTH-1:0] CMD_CLEAR  = N_WIDTH'(0);
  localparam logic [N_WIDTH-1:0] CMD_GO     = N_WIDTH'(1);
  localparam logic [N_WIDTH-1:0] CMD_STATUS = N_WIDTH'(3);

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [OW-1:0]         OUT_FULL = OW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  state_t                             state_q, state_d;
  logic [N_WIDTH-1:0]                 cmd_q, cmd_d;
  logic [DATA_WIDTH-1:0]              a_q, a_d;
  logic [DATA_WIDTH-1:0]              b_q, b_d;
  logic [OW-1:0]                      out_q, out_d;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]  sum_q, sum_d;
  logic [NUM_CH-1:0]                  ovf_q, ovf_d;
  logic                               stray_q, stray_d;
  logic                               bad_q, bad_d;
  logic [DATA_WIDTH-1:0]              result_q, result_d;

  logic                               hs;
  logic                               ret_acc;
  logic                               ret_stray;
  logic                               drain_empty;
  logic                               clear_now;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]  sat_sum;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]  acc_sum;
  logic [NUM_CH-1:0]                  sat_ovf;
  logic [DATA_WIDTH-1:0]              read_val;
  logic [2:0]                         sel;

  // Credits are judged on the registered count, so a return in a full cycle
  // only re-opens issue on the following cycle.
  assign issue_valid = clk_en && (state_q == ISSUE) && (out_q != OUT_FULL);
  assign hs          = issue_valid && issue_ready;
  // A return with nothing outstanding is discarded entirely.
  assign ret_acc     = clk_en && ret_valid && (out_q != '0);
  assign ret_stray   = clk_en && ret_valid && (out_q == '0);
  // Empty once this cycle's return (if any) is counted.
  assign drain_empty = (out_q == '0) || ((out_q == OW'(1)) && ret_acc);

  assign done    = clk_en && (state_q == RESP);
  assign busy    = (state_q != IDLE);
  assign result  = result_q;
  assign issue_a = a_q;
  assign issue_b = b_q;
  assign sel     = a_q[2:0];

  // Per-channel signed saturating adder.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [DATA_WIDTH-1:0] term;
    logic [DATA_WIDTH:0]   wide;
    assign term = ret_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign wide = {sum_q[gi][DATA_WIDTH-1], sum_q[gi]} + {term[DATA_WIDTH-1], term};
    // The sign-extended sum overflowed when its two top bits disagree;
    // the top bit then carries the true sign.
    assign sat_ovf[gi] = wide[DATA_WIDTH] ^ wide[DATA_WIDTH-1];
    assign sat_sum[gi] = sat_ovf[gi] ? (wide[DATA_WIDTH] ? SAT_MIN : SAT_MAX)
                                     : wide[DATA_WIDTH-1:0];
    assign acc_sum[gi] = ret_acc ? sat_sum[gi] : sum_q[gi];
  end

  // READ sees the sums including any term returned in the completing cycle.
  always_comb begin
    read_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel == 3'(c)) read_val = acc_sum[c];
    end
  end

  always_comb begin
    sum_d = acc_sum;
    ovf_d = ret_acc ? (ovf_q | sat_ovf) : ovf_q;
    if (clear_now) begin
      sum_d = '0;
      ovf_d = '0;
    end
  end

  always_comb begin
    out_d = out_q;
    if (hs && !ret_acc)      out_d = out_q + OW'(1);
    else if (!hs && ret_acc) out_d = out_q - OW'(1);
  end

  assign stray_d = stray_q | ret_stray;

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    bad_d     = bad_q;
    clear_now = 1'b0;
    if (clk_en) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cmd_d = n;
            a_d   = x_one;
            b_d   = x_two;
            if (n == CMD_GO) begin
              state_d = ISSUE;
            end else if (n == CMD_STATUS) begin
              state_d  = RESP;
              result_d = DATA_WIDTH'({bad_q, stray_q, ovf_q, out_q});
            end else begin
              state_d = DRAIN;
            end
          end
        end
        ISSUE: begin
          if (hs) begin
            state_d  = RESP;
            result_d = '0;
          end
        end
        DRAIN: begin
          if (drain_empty) begin
            state_d = RESP;
            if (cmd_q == CMD_CLEAR) begin
              clear_now = 1'b1;
              result_d  = '0;
            end else if (32'(sel) < NUM_CH) begin
              result_d = read_val;
            end else begin
              result_d = '0;
              bad_d    = 1'b1;
            end
          end
        end
        RESP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      out_q    <= '0;
      sum_q    <= '0;
      ovf_q    <= '0;
      stray_q  <= 1'b0;
      bad_q    <= 1'b0;
      result_q <= '0;
    end else if (clk_en) begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      out_q    <= out_d;
      sum_q    <= sum_d;
      ovf_q    <= ovf_d;
      stray_q  <= stray_d;
      bad_q    <= bad_d;
      result_q <= result_d;
    end
  end

  // Status word must fit in the result.
  if (STAT_W > DATA_WIDTH) begin : g_bad_width
    $error("status word wider than DATA_WIDTH");
  end

endmodule

// File: tb/tb_function_eval_accumulator.sv
// -----------------------------------------------------------------------------
// Bench for function_eval_accumulator. A behavioural model (integer sums,
// plain counters, command phase) is stepped once per clock from the inputs
// the bench drives; every cycle the DUT outputs are compared with it.
// Directed scenarios add literal checks on the responses.
// -----------------------------------------------------------------------------
module tb_function_eval_accumulator;
  localparam int DW = 32;
  localparam int NW = 2;
  localparam int NC = 2;
  localparam int MO = 8;
  localparam int OW = 4;

  logic clk = 1'b0;
  logic rst, clk_en, start, issue_ready, ret_valid;
  logic [NW-1:0] n;
  logic [DW-1:0] x_one, x_two, result, issue_a, issue_b;
  logic done, busy, issue_valid;
  logic [NC*DW-1:0] ret_data;

  function_eval_accumulator #(
    .DATA_WIDTH(DW), .N_WIDTH(NW), .NUM_CH(NC), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start), .n(n),
    .x_one(x_one), .x_two(x_two), .result(result), .done(done), .busy(busy),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_a(issue_a), .issue_b(issue_b),
    .ret_valid(ret_valid), .ret_data(ret_data)
  );

  always #5 clk = ~clk;

  // Model: 0 idle, 1 issuing, 2 draining, 3 responding.
  int            m_phase;
  int            m_cmd;
  logic [DW-1:0] m_a, m_b, m_res;
  int            m_out;
  longint        m_sum [NC];
  bit            m_ovf [NC];
  bit            m_stray, m_bad;

  int            checks = 0;
  int            errors = 0;
  logic          seen_done, seen_iv, seen_busy;
  logic [DW-1:0] seen_res;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_cmd = 0; m_a = '0; m_b = '0; m_res = '0; m_out = 0;
    for (int c = 0; c < NC; c++) begin m_sum[c] = 0; m_ovf[c] = 0; end
    m_stray = 0; m_bad = 0;
  endtask

  task automatic model_step(input bit hs);
    longint        ns [NC];
    bit            novf [NC];
    bit            acc;
    longint        tmp;
    logic [DW-1:0] raw;
    logic signed [DW-1:0] term;
    int            stat, sel;
    acc = ret_valid && (m_out != 0);
    for (int c = 0; c < NC; c++) begin
      ns[c] = m_sum[c]; novf[c] = m_ovf[c];
      if (acc) begin
        raw  = ret_data[c*DW +: DW];
        term = raw;
        ns[c] = m_sum[c] + longint'(term);
        if (ns[c] > 64'sd2147483647) begin ns[c] = 64'sd2147483647; novf[c] = 1; end
        if (ns[c] < -64'sd2147483648) begin ns[c] = -64'sd2147483648; novf[c] = 1; end
      end
    end
    case (m_phase)
      0: if (start) begin
           m_cmd = int'(n); m_a = x_one; m_b = x_two;
           if (m_cmd == 1) m_phase = 1;
           else if (m_cmd == 3) begin
             stat = m_out;
             for (int c = 0; c < NC; c++) stat += int'(m_ovf[c]) << (OW + c);
             stat += int'(m_stray) << (OW + NC);
             stat += int'(m_bad) << (OW + NC + 1);
             m_res = DW'(stat);
             m_phase = 3;
           end else m_phase = 2;
         end
      1: if (hs) begin m_phase = 3; m_res = '0; end
      2: if (m_out - int'(acc) == 0) begin
           m_phase = 3;
           if (m_cmd == 0) begin
             for (int c = 0; c < NC; c++) begin ns[c] = 0; novf[c] = 0; end
             m_res = '0;
           end else begin
             sel = int'(m_a[2:0]);
             if (sel < NC) begin tmp = ns[sel]; m_res = tmp[DW-1:0]; end
             else begin m_res = '0; m_bad = 1; end
           end
         end
      default: m_phase = 0;
    endcase
    for (int c = 0; c < NC; c++) begin m_sum[c] = ns[c]; m_ovf[c] = novf[c]; end
    if (ret_valid && m_out == 0) m_stray = 1;
    m_out = m_out + int'(hs) - int'(acc);
  endtask

  // One clock: inputs already driven at the falling edge.
  task automatic cycle();
    bit exp_iv;
    #1;
    if (rst) model_reset();
    exp_iv = clk_en && !rst && (m_phase == 1) && (m_out < MO);
    chk("busy", busy, m_phase != 0);
    chk("done", done, clk_en && !rst && (m_phase == 3));
    chk("issue_valid", issue_valid, exp_iv);
    chk("result", result, m_res);
    if (m_phase == 1) begin
      chk("issue_a", issue_a, m_a);
      chk("issue_b", issue_b, m_b);
    end
    seen_done = done; seen_res = result; seen_iv = issue_valid; seen_busy = busy;
    @(posedge clk);
    if (!rst && clk_en) model_step(exp_iv && issue_ready);
    @(negedge clk);
  endtask

  task automatic wait_done(input string nm, output int lat);
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      cycle();
      if (seen_done) lat = i;
    end
    if (lat == 0) begin
      errors++; checks++;
      $display("FAIL %s_timeout: got no done expected done within 40 cycles", nm);
    end
  endtask

  task automatic send_start(input int cmd, input logic [DW-1:0] a);
    start = 1'b1; n = NW'(cmd); x_one = a; x_two = a ^ 32'h5A5A_0001;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_cmd(input string nm, input int cmd, input logic [DW-1:0] a,
                         input int exp_lat, input logic [DW-1:0] exp_res);
    int lat;
    send_start(cmd, a);
    wait_done(nm, lat);
    chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({nm, "_res"}, seen_res, exp_res);
    $display("cmd %s n=%0d a=%0h latency=%0d result=%0h", nm, cmd, a, lat, seen_res);
  endtask

  task automatic ret_pulse(input logic [DW-1:0] t0, input logic [DW-1:0] t1);
    ret_valid = 1'b1; ret_data = {t1, t0};
    cycle();
    ret_valid = 1'b0; ret_data = '0;
  endtask

  int lat;

  initial begin
    rst = 1'b1; clk_en = 1'b1; start = 1'b0; n = '0; x_one = '0; x_two = '0;
    issue_ready = 1'b1; ret_valid = 1'b0; ret_data = '0;
    model_reset();
    @(negedge clk);
    cycle(); cycle();
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    cycle();

    // Status straight after reset.
    run_cmd("status0", 3, 0, 1, 32'h0);

    // Three GOs, each returning {5,-2}.
    for (int k = 0; k < 3; k++) begin
      run_cmd("go", 1, 32'(k + 10), 2, 32'h0);
      ret_pulse(32'd5, 32'hFFFF_FFFE);
    end
    run_cmd("read_ch0", 2, 0, 2, 32'd15);
    run_cmd("read_ch1", 2, 1, 2, 32'hFFFF_FFFA);
    run_cmd("status1", 3, 0, 1, 32'h0);

    // Fill the credit window, then one more GO must stall.
    for (int k = 0; k < MO; k++) run_cmd("go_fill", 1, 32'(k), 2, 32'h0);
    run_cmd("status_full", 3, 0, 1, 32'h8);
    send_start(1, 32'hABCD);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("full_iv", seen_iv, 0);
      chk("full_busy", seen_busy, 1);
    end
    ret_pulse(32'h0, 32'h0);
    chk("full_iv_ret", seen_iv, 0);
    wait_done("go_after_ret", lat);
    chk("go_after_ret_lat", 64'(lat), 2);
    $display("cmd go_after_ret latency=%0d result=%0h", lat, seen_res);
    for (int k = 0; k < MO; k++) ret_pulse(32'h0, 32'h0);
    run_cmd("status_empty", 3, 0, 1, 32'h0);

    // Saturation in both directions.
    run_cmd("clear0", 0, 0, 2, 32'h0);
    run_cmd("go_s", 1, 1, 2, 32'h0);  ret_pulse(32'h7FFF_FFF0, 32'h0);
    run_cmd("go_s", 1, 2, 2, 32'h0);  ret_pulse(32'h0000_0020, 32'h0);
    run_cmd("read_sat0", 2, 0, 2, 32'h7FFF_FFFF);
    run_cmd("status_ovf0", 3, 0, 1, 32'h10);
    run_cmd("go_s", 1, 3, 2, 32'h0);  ret_pulse(32'h0, 32'h8000_0000);
    run_cmd("go_s", 1, 4, 2, 32'h0);  ret_pulse(32'h0, 32'h8000_0000);
    run_cmd("read_sat1", 2, 1, 2, 32'h8000_0000);
    run_cmd("status_ovf01", 3, 0, 1, 32'h30);
    run_cmd("clear1", 0, 0, 2, 32'h0);
    run_cmd("read_clr", 2, 0, 2, 32'h0);
    run_cmd("status_clr", 3, 0, 1, 32'h0);

    // READ waits for two in-flight returns.
    run_cmd("go_d", 1, 5, 2, 32'h0);
    run_cmd("go_d", 1, 6, 2, 32'h0);
    send_start(2, 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("drain_nodone", seen_done, 0);
    end
    ret_pulse(32'd1, 32'd2);
    cycle(); cycle();
    chk("drain_nodone2", seen_done, 0);
    ret_pulse(32'd3, 32'd4);
    wait_done("read_drain", lat);
    chk("read_drain_lat", 64'(lat), 1);
    chk("read_drain_res", seen_res, 32'd4);
    $display("cmd read_drain latency=%0d result=%0h", lat, seen_res);
    run_cmd("read_drain1", 2, 1, 2, 32'd6);
    run_cmd("read_bad", 2, 5, 2, 32'h0);
    run_cmd("status_bad", 3, 0, 1, 32'h80);

    // clk_en low while stuck in ISSUE.
    issue_ready = 1'b0;
    send_start(1, 32'h77);
    cycle(); cycle();
    clk_en = 1'b0; ret_valid = 1'b1; ret_data = {32'd100, 32'd100};
    start = 1'b1; n = NW'(3);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("frozen_busy", seen_busy, 1);
      chk("frozen_iv", seen_iv, 0);
    end
    clk_en = 1'b1; ret_valid = 1'b0; ret_data = '0; start = 1'b0; issue_ready = 1'b1;
    wait_done("go_resume", lat);
    chk("go_resume_lat", 64'(lat), 2);
    $display("cmd go_resume latency=%0d result=%0h", lat, seen_res);

    // Reset while a READ is draining, then a late return is stray.
    send_start(2, 0);
    cycle(); cycle();
    chk("pre_rst_busy", seen_busy, 1);
    rst = 1'b1;
    cycle();
    chk("mid_rst_busy", seen_busy, 0);
    chk("mid_rst_res", seen_res, 0);
    rst = 1'b0;
    cycle();
    ret_pulse(32'd9, 32'd9);
    run_cmd("status_stray", 3, 0, 1, 32'h40);
    run_cmd("read_after_stray", 2, 0, 2, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
